// File: rtl/sdram_pattern_tester.sv
// Drives the Max10 SDRAM controller request port: writes an LFSR pattern over an
// address window, reads it back, and reports mismatches and handshake timeouts.
module sdram_pattern_tester #(
    parameter logic [24:0] ADDR_START = 25'd0,
    parameter logic [24:0] ADDR_COUNT = 25'd1024,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic [15:0] TIMEOUT    = 16'd1023
) (
    input  logic        activeClock,
    input  logic        reset_n,
    input  logic        start,
    output logic [24:0] sdram_address,
    output logic [15:0] sdram_inputData,
    output logic        sdram_isWriting,
    output logic        sdram_inputValid,
    input  logic [15:0] sdram_outputData,
    input  logic        sdram_outputValid,
    input  logic        sdram_isBusy,
    input  logic        sdram_recievedCommand,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timedOut,
    output logic [15:0] errorCount,
    output logic [24:0] firstErrorAddress,
    output logic [15:0] firstErrorExpected,
    output logic [15:0] firstErrorActual
);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE} state_t;

    state_t      state, stateNext;
    logic [24:0] index, indexNext, indexInc;
    logic [15:0] lfsr, lfsrNext, lfsrStep;
    logic [15:0] timer, timerNext;
    logic [24:0] addressNext;
    logic [15:0] inputDataNext;
    logic        isWritingNext, inputValidNext;
    logic        busyNext, doneNext, passNext, timedOutNext;
    logic [15:0] errorCountNext;
    logic [24:0] firstErrorAddressNext;
    logic [15:0] firstErrorExpectedNext, firstErrorActualNext;
    logic        lastWord, timerExpired, issueNext;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    assign lfsrStep     = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign indexInc     = index + 25'd1;
    assign lastWord     = (indexInc == ADDR_COUNT);
    assign timerExpired = ((timer + 16'd1) == TIMEOUT);

    always_ff @(posedge activeClock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            index              <= '0;
            lfsr               <= SEED;
            timer              <= '0;
            sdram_address      <= '0;
            sdram_inputData    <= '0;
            sdram_isWriting    <= 1'b0;
            sdram_inputValid   <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            timedOut           <= 1'b0;
            errorCount         <= '0;
            firstErrorAddress  <= '0;
            firstErrorExpected <= '0;
            firstErrorActual   <= '0;
        end else begin
            state              <= stateNext;
            index              <= indexNext;
            lfsr               <= lfsrNext;
            timer              <= timerNext;
            sdram_address      <= addressNext;
            sdram_inputData    <= inputDataNext;
            sdram_isWriting    <= isWritingNext;
            sdram_inputValid   <= inputValidNext;
            busy               <= busyNext;
            done               <= doneNext;
            pass               <= passNext;
            timedOut           <= timedOutNext;
            errorCount         <= errorCountNext;
            firstErrorAddress  <= firstErrorAddressNext;
            firstErrorExpected <= firstErrorExpectedNext;
            firstErrorActual   <= firstErrorActualNext;
        end
    end

    always_comb begin
        stateNext              = state;
        indexNext              = index;
        lfsrNext               = lfsr;
        timerNext              = timer;
        addressNext            = sdram_address;
        busyNext               = busy;
        doneNext               = done;
        passNext               = pass;
        timedOutNext           = timedOut;
        errorCountNext         = errorCount;
        firstErrorAddressNext  = firstErrorAddress;
        firstErrorExpectedNext = firstErrorExpected;
        firstErrorActualNext   = firstErrorActual;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    errorCountNext         = '0;
                    firstErrorAddressNext  = '0;
                    firstErrorExpectedNext = '0;
                    firstErrorActualNext   = '0;
                    timedOutNext           = 1'b0;
                    doneNext               = 1'b0;
                    passNext               = 1'b0;
                    busyNext               = 1'b1;
                    indexNext              = '0;
                    lfsrNext               = SEED;
                    stateNext              = WR_ISSUE;
                end
            end
            WR_ISSUE, RD_ISSUE: begin
                if (timerExpired) begin
                    timedOutNext = 1'b1;
                    stateNext    = DONE;
                end else if (sdram_recievedCommand) begin
                    stateNext = (state == WR_ISSUE) ? WR_WAIT : RD_WAIT;
                end else begin
                    timerNext = timer + 16'd1;
                end
            end
            WR_WAIT: begin
                if (timerExpired) begin
                    timedOutNext = 1'b1;
                    stateNext    = DONE;
                end else if (!sdram_isBusy) begin
                    if (lastWord) begin
                        indexNext = '0;
                        lfsrNext  = SEED;
                        stateNext = RD_ISSUE;
                    end else begin
                        indexNext = indexInc;
                        lfsrNext  = lfsrStep;
                        stateNext = WR_ISSUE;
                    end
                end else begin
                    timerNext = timer + 16'd1;
                end
            end
            RD_WAIT: begin
                // Data arriving on the same cycle as the timeout is still scored.
                if (sdram_outputValid) begin
                    if (sdram_outputData != lfsr) begin
                        if (errorCount == 16'h0000) begin
                            firstErrorAddressNext  = sdram_address;
                            firstErrorExpectedNext = lfsr;
                            firstErrorActualNext   = sdram_outputData;
                        end
                        if (errorCount != 16'hFFFF) begin
                            errorCountNext = errorCount + 16'd1;
                        end
                    end
                    indexNext = indexInc;
                    lfsrNext  = lfsrStep;
                    stateNext = lastWord ? DONE : RD_ISSUE;
                end
                if (timerExpired) begin
                    timedOutNext = 1'b1;
                    stateNext    = DONE;
                end else if (!sdram_outputValid) begin
                    timerNext = timer + 16'd1;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (stateNext != state) begin
            timerNext = '0;
        end

        if (stateNext == DONE && state != DONE) begin
            busyNext = 1'b0;
            doneNext = 1'b1;
            passNext = (errorCountNext == 16'h0000) && !timedOutNext;
        end

        // Request fields are loaded on entry to an issue state and held until acknowledged.
        issueNext      = (stateNext == WR_ISSUE) || (stateNext == RD_ISSUE);
        inputValidNext = issueNext;
        isWritingNext  = (stateNext == WR_ISSUE);
        inputDataNext  = (stateNext == WR_ISSUE) ? lfsrNext : 16'h0000;
        if (issueNext && stateNext != state) begin
            addressNext = ADDR_START + indexNext;
        end
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Scoreboard bench: a behavioural SDRAM controller model checks each issued command
// against a queue of expected commands; a status monitor checks each run's result.
module tb_sdram_pattern_tester;

    localparam int          COUNT = 4;
    localparam logic [24:0] START = 25'd0;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [15:0] TMO   = 16'd20;

    logic        activeClock;
    logic        reset_n;
    logic        start;
    logic [24:0] sdram_address;
    logic [15:0] sdram_inputData;
    logic        sdram_isWriting;
    logic        sdram_inputValid;
    logic [15:0] sdram_outputData;
    logic        sdram_outputValid;
    logic        sdram_isBusy;
    logic        sdram_recievedCommand;
    logic        busy, done, pass, timedOut;
    logic [15:0] errorCount;
    logic [24:0] firstErrorAddress;
    logic [15:0] firstErrorExpected, firstErrorActual;

    typedef struct packed {
        logic [24:0] addr;
        logic        isWr;
        logic [15:0] data;
    } cmd_t;

    typedef struct {
        logic        timedOut;
        logic        pass;
        logic [15:0] errCnt;
        logic [24:0] fAddr;
        logic [15:0] fExp;
        logic [15:0] fAct;
        int          acks;
        int          leftover;
    } status_t;

    cmd_t        cmdQ[$];
    status_t     statQ[$];
    logic [15:0] mem [logic [24:0]];
    logic [15:0] corrupt [COUNT];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int ackCount = 0;
    int runAckBase = 0;
    int ackCycleDrop = 0;
    int ackDelay, readLat, busyLen;
    bit earlyDrop, dropFirstRead, strayValid;

    sdram_pattern_tester #(
        .ADDR_START(START),
        .ADDR_COUNT(25'(COUNT)),
        .SEED(SEED),
        .TIMEOUT(TMO)
    ) dut (
        .activeClock(activeClock),
        .reset_n(reset_n),
        .start(start),
        .sdram_address(sdram_address),
        .sdram_inputData(sdram_inputData),
        .sdram_isWriting(sdram_isWriting),
        .sdram_inputValid(sdram_inputValid),
        .sdram_outputData(sdram_outputData),
        .sdram_outputValid(sdram_outputValid),
        .sdram_isBusy(sdram_isBusy),
        .sdram_recievedCommand(sdram_recievedCommand),
        .busy(busy),
        .done(done),
        .pass(pass),
        .timedOut(timedOut),
        .errorCount(errorCount),
        .firstErrorAddress(firstErrorAddress),
        .firstErrorExpected(firstErrorExpected),
        .firstErrorActual(firstErrorActual)
    );

    initial begin
        activeClock = 1'b0;
        forever #5 activeClock = ~activeClock;
    end

    initial begin
        forever begin
            @(posedge activeClock);
            cyc++;
        end
    end

    function automatic logic [15:0] nextPattern(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Controller model: acknowledges after ackDelay cycles, then completes the access.
    initial begin
        cmd_t cur;
        cmd_t want;
        int   phase;
        int   left;
        int   idx;
        logic [15:0] rd;
        phase = 0;
        left = 0;
        cur = '0;
        sdram_outputData = '0;
        sdram_outputValid = 1'b0;
        sdram_isBusy = 1'b0;
        sdram_recievedCommand = 1'b0;
        forever begin
            @(negedge activeClock);
            sdram_recievedCommand = 1'b0;
            sdram_outputValid = 1'b0;
            if (!reset_n) begin
                phase = 0;
                sdram_isBusy = 1'b0;
                continue;
            end
            case (phase)
                1: begin
                    checkOutput("inputValid held", 32'(sdram_inputValid), 32'd1);
                    checkOutput("address stable", 32'(sdram_address), 32'(cur.addr));
                    checkOutput("data stable", 32'(sdram_inputData), 32'(cur.data));
                    if (earlyDrop && cur.isWr) sdram_isBusy = 1'b0;
                end
                2: begin
                    if (left == 0) begin
                        sdram_isBusy = 1'b0;
                        phase = 0;
                    end else begin
                        left--;
                        if (strayValid) begin
                            sdram_outputValid = 1'b1;
                            sdram_outputData = 16'($urandom);
                        end
                    end
                end
                3: begin
                    if (left == 0) begin
                        idx = int'(cur.addr - START);
                        rd = mem.exists(cur.addr) ? mem[cur.addr] : 16'hDEAD;
                        if (idx >= 0 && idx < COUNT) rd = rd ^ corrupt[idx];
                        sdram_outputData = rd;
                        sdram_outputValid = 1'b1;
                        sdram_isBusy = 1'b0;
                        phase = 0;
                    end else begin
                        left--;
                    end
                end
                4: begin
                    if (!busy) begin
                        sdram_isBusy = 1'b0;
                        phase = 0;
                    end
                end
                default: begin
                    if (sdram_inputValid) begin
                        cur = '{sdram_address, sdram_isWriting, sdram_inputData};
                        if (cmdQ.size() == 0) begin
                            checkOutput("unexpected command", 32'(cur.addr), 32'h1FFFFFF);
                        end else begin
                            want = cmdQ.pop_front();
                            checkOutput("cmd address", 32'(cur.addr), 32'(want.addr));
                            checkOutput("cmd isWriting", 32'(cur.isWr), 32'(want.isWr));
                            checkOutput("cmd data", 32'(cur.data), 32'(want.data));
                        end
                        sdram_isBusy = 1'b1;
                        left = ackDelay;
                        phase = 1;
                    end
                end
            endcase
            if (phase == 1) begin
                if (left == 0) begin
                    sdram_recievedCommand = 1'b1;
                    ackCount++;
                    if (cur.isWr) begin
                        mem[cur.addr] = cur.data;
                        left = busyLen;
                        if (earlyDrop) begin
                            sdram_isBusy = 1'b0;
                            phase = 0;
                        end else begin
                            phase = 2;
                        end
                    end else if (dropFirstRead) begin
                        dropFirstRead = 1'b0;
                        ackCycleDrop = cyc;
                        phase = 4;
                    end else begin
                        left = readLat;
                        phase = 3;
                    end
                end else begin
                    left--;
                end
            end
        end
    end

    // Status monitor: scores each run when done rises.
    initial begin
        status_t s;
        logic    prevDone;
        prevDone = 1'b0;
        forever begin
            @(negedge activeClock);
            if (!reset_n) begin
                prevDone = 1'b0;
                continue;
            end
            if (done && !prevDone) begin
                if (statQ.size() == 0) begin
                    checkOutput("unexpected done", 32'(done), 32'd0);
                end else begin
                    s = statQ.pop_front();
                    checkOutput("timedOut", 32'(timedOut), 32'(s.timedOut));
                    checkOutput("pass", 32'(pass), 32'(s.pass));
                    checkOutput("errorCount", 32'(errorCount), 32'(s.errCnt));
                    checkOutput("firstErrorAddress", 32'(firstErrorAddress), 32'(s.fAddr));
                    checkOutput("firstErrorExpected", 32'(firstErrorExpected), 32'(s.fExp));
                    checkOutput("firstErrorActual", 32'(firstErrorActual), 32'(s.fAct));
                    checkOutput("busy at done", 32'(busy), 32'd0);
                    checkOutput("inputValid at done", 32'(sdram_inputValid), 32'd0);
                    checkOutput("ack count", 32'(ackCount - runAckBase), 32'(s.acks));
                    checkOutput("commands left", 32'(cmdQ.size()), 32'(s.leftover));
                    if (s.timedOut) checkOutput("timeout cycle", 32'(cyc - ackCycleDrop), 32'd21);
                end
            end
            prevDone = done;
        end
    end

    task automatic applyStimulus(input int aDly, input int rLat, input int bLen, input bit early,
                                 input bit drop, input bit strayV, input bit midStart, input bit waitDone);
        logic [15:0] pat [COUNT];
        logic [15:0] l;
        status_t     s;
        ackDelay = aDly;
        readLat = rLat;
        busyLen = bLen;
        earlyDrop = early;
        dropFirstRead = drop;
        strayValid = strayV;
        l = SEED;
        for (int i = 0; i < COUNT; i++) begin
            pat[i] = l;
            l = nextPattern(l);
        end
        for (int i = 0; i < COUNT; i++) cmdQ.push_back('{START + 25'(i), 1'b1, pat[i]});
        for (int i = 0; i < COUNT; i++) cmdQ.push_back('{START + 25'(i), 1'b0, 16'h0000});
        s.timedOut = drop;
        s.errCnt = '0;
        s.fAddr = '0;
        s.fExp = '0;
        s.fAct = '0;
        if (!drop) begin
            for (int i = 0; i < COUNT; i++) begin
                if (corrupt[i] != 16'h0000) begin
                    if (s.errCnt == 16'h0000) begin
                        s.fAddr = START + 25'(i);
                        s.fExp = pat[i];
                        s.fAct = pat[i] ^ corrupt[i];
                    end
                    s.errCnt++;
                end
            end
        end
        s.pass = !drop && (s.errCnt == 16'h0000);
        s.acks = drop ? COUNT + 1 : 2 * COUNT;
        s.leftover = drop ? COUNT - 1 : 0;
        statQ.push_back(s);
        runAckBase = ackCount;
        @(negedge activeClock);
        start = 1'b1;
        @(negedge activeClock);
        start = 1'b0;
        checkOutput("busy after start", 32'(busy), 32'd1);
        checkOutput("done cleared by start", 32'(done), 32'd0);
        checkOutput("timedOut cleared by start", 32'(timedOut), 32'd0);
        checkOutput("errorCount cleared by start", 32'(errorCount), 32'd0);
        if (midStart) begin
            repeat (10) @(negedge activeClock);
            start = 1'b1;
            @(negedge activeClock);
            start = 1'b0;
        end
        if (waitDone) begin
            for (int k = 0; k < 600 && !done; k++) @(negedge activeClock);
            if (!done) checkOutput("run completes", 32'(done), 32'd1);
            repeat (3) @(negedge activeClock);
            cmdQ.delete();
            statQ.delete();
        end
    endtask

    initial begin
        reset_n = 1'b1;
        start = 1'b0;
        foreach (corrupt[i]) corrupt[i] = '0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset flags", 32'({busy, done, pass, timedOut, sdram_inputValid, sdram_isWriting}), 32'd0);
        checkOutput("reset address", 32'(sdram_address), 32'd0);
        checkOutput("reset errorCount", 32'(errorCount), 32'd0);
        repeat (2) @(negedge activeClock);
        reset_n = 1'b1;

        // Clean run, then one corrupted word at address 2.
        applyStimulus(1, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        corrupt[2] = 16'h0001;
        applyStimulus(1, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        corrupt[2] = 16'h0000;
        // Slow acknowledge with early isBusy drop on writes.
        applyStimulus(5, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // First read never returns data.
        applyStimulus(0, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        // Rerun from DONE with a mid-run start pulse and stray read-valid pulses.
        applyStimulus(2, 1, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            foreach (corrupt[i]) corrupt[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                          1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        foreach (corrupt[i]) corrupt[i] = '0;

        // Reset between clock edges while waiting on the second write.
        applyStimulus(1, 2, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 200 && (ackCount - runAckBase) < 2; k++) @(negedge activeClock);
        checkOutput("second write acknowledged", 32'(ackCount - runAckBase), 32'd2);
        @(negedge activeClock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset flags", 32'({busy, done, pass, timedOut, sdram_inputValid, sdram_isWriting}), 32'd0);
        checkOutput("async reset address", 32'(sdram_address), 32'd0);
        checkOutput("async reset data", 32'(sdram_inputData), 32'd0);
        repeat (2) @(negedge activeClock);
        cmdQ.delete();
        statQ.delete();
        reset_n = 1'b1;
        applyStimulus(1, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
- Self-checking traffic generator that sits directly upstream of the Max10 SDRAM controller and drives its request interface: address, inputData, isWriting, inputValid.
- Writes an LFSR pseudo-random pattern over a programmable address window, then reads the window back and compares against the regenerated pattern.
- Reports pass/fail, error count, first-failure details and a command timeout.
- Used for board bring-up and regression of the SDRAM path.

Parameters:
- ADDR_START, 25'd0, first word address ({bank[1:0], row[12:0], col[9:0]}).
- ADDR_COUNT, 25'd1024, number of words tested; must be ≥1.
- SEED, 16'hACE1, LFSR seed; must be nonzero.
- TIMEOUT, 16'd1023, maximum cycles to wait for any single controller handshake.

Ports:
- activeClock  in  1  system clock, same clock as the SDRAM controller.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a test run.
- sdram_address  out  25  to controller `address`.
- sdram_inputData  out  16  to controller `inputData`.
- sdram_isWriting  out  1  to controller `isWriting`.
- sdram_inputValid  out  1  to controller `inputValid`.
- sdram_outputData  in  16  from controller `outputData`.
- sdram_outputValid  in  1  from controller `outputValid`.
- sdram_isBusy  in  1  from controller `isBusy`.
- sdram_recievedCommand  in  1  from controller `recievedCommand` (acceptance acknowledge).
- busy  out  1  high while a run is in progress.
- done  out  1  high from run end until the next accepted start or reset.
- pass  out  1  valid when done: 1 only if errorCount==0 and no timeout.
- timedOut  out  1  a handshake exceeded TIMEOUT.
- errorCount  out  16  mismatch count, saturates at 16'hFFFF.
- firstErrorAddress  out  25  address of the first mismatch.
- firstErrorExpected  out  16  expected data at the first mismatch.
- firstErrorActual  out  16  read data at the first mismatch.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE.
  - All outputs 0, including sdram_* and first-error fields.
  - index=0, lfsr=SEED, timeout counter=0.
- LFSR: 16-bit Galois, right shift, polynomial x^16+x^14+x^13+x^11+1.
  - next = (l>>1) ^ (l[0] ? 16'hB400 : 0).
  - Sequence from ACE1: ACE1 → E270 → 7138.
- Address: sdram_address = ADDR_START + index, 25-bit, wraps modulo 2^25. The address is registered and stable while sdram_inputValid is high.
- States:
  - IDLE: on start, clear errorCount, first-error fields, timedOut, done and pass; index=0; lfsr=SEED; busy=1; go to WR_ISSUE. start is ignored in every other state except DONE.
  - WR_ISSUE: drive isWriting=1, inputData=lfsr, inputValid=1. Hold all of them until sdram_recievedCommand=1 is sampled. On the cycle after that sample, drop inputValid and go to WR_WAIT.
  - WR_WAIT: wait for sdram_isBusy=0. Then advance lfsr and increment index.
    - If index==ADDR_COUNT: index=0, lfsr=SEED, go to RD_ISSUE.
    - Else go to WR_ISSUE.
    - inputValid being held until the acknowledge absorbs the controller's early isBusy drop before it returns to idle.
  - RD_ISSUE: as WR_ISSUE, but isWriting=0 and inputData=0.
  - RD_WAIT: wait for sdram_outputValid=1 and capture sdram_outputData on that cycle.
    - Compare the captured data with lfsr.
    - On mismatch: errorCount++ (saturating). If errorCount was 0 before the increment, latch address, expected and actual.
    - Then advance lfsr and index. If index==ADDR_COUNT go to DONE, else go to RD_ISSUE.
  - DONE: busy=0, done=1, pass=(errorCount==0 && !timedOut). A start here behaves exactly as start in IDLE.
- Timeout:
  - The counter clears on every state entry and increments each cycle in the ISSUE and WAIT states.
  - On reaching TIMEOUT: timedOut=1, inputValid=0, go to DONE.
- Simultaneous events: if outputValid and the timeout fire in the same cycle, the data is compared and timedOut is still set.
- Reset mid-run: abort immediately; inputValid drops asynchronously; no status is retained.
- A stray sdram_outputValid outside RD_WAIT is ignored.

Test Plan:
- Test 1, clean run: ADDR_COUNT=4, SEED=ACE1, behavioural controller model, start pulse.
  - Write data ACE1, E270, 7138, 389C to addresses 0..3.
  - 4 reads, then done=1, pass=1, errorCount=0, busy low.
- Test 2, corrupted readback: model returns 7139 at address 2.
  - errorCount=1, firstErrorAddress=2, firstErrorExpected=7138, firstErrorActual=7139, pass=0.
- Test 3, acknowledge timing: model delays sdram_recievedCommand by 5 cycles and drops isBusy early on writes.
  - inputValid held steady with stable address and data until the acknowledge.
  - No duplicate or lost commands; exactly 2×ADDR_COUNT acknowledges.
- Test 4, timeout: model never asserts outputValid on the first read, TIMEOUT=20.
  - timedOut=1 exactly 20 cycles into RD_WAIT, done=1, pass=0, inputValid=0.
- Test 5, start handling: start pulsed mid-run is ignored (index continues). start in DONE reruns, clearing errorCount and timedOut.
- Test 6, reset mid-run: reset_n asserted during WR_WAIT, asynchronously and between clock edges.
  - All outputs 0 immediately.
  - After release and a new start, the first write again uses ACE1 at ADDR_START.
